// File: rtl/cpu_debug_ocimem_pkg.sv
// cpu_debug_ocimem_pkg: shared state, command and jdo field
// definitions for the OCI memory sequencer.
package cpu_debug_ocimem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_LOAD,
    CMD_READ,
    CMD_WRITE
  } cmd_e;

  localparam int JDO_RDFLAG    = 35;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;

  // a-action beats no_action_a beats b-action
  function automatic cmd_e pick_cmd(
    input logic a,
    input logic na,
    input logic b
  );
    if (a) return CMD_LOAD;
    if (na) return CMD_READ;
    if (b) return CMD_WRITE;
    return CMD_NONE;
  endfunction

  function automatic logic lost_cmd(
    input logic a,
    input logic na,
    input logic b
  );
    return (a && (na || b)) || (na && b);
  endfunction

endpackage

// File: rtl/cpu_debug_ocimem_timeout.sv
// cpu_debug_ocimem_timeout: saturating cycle counter that flags
// the last permitted cycle of an outstanding access.
module cpu_debug_ocimem_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LAST) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/cpu_debug_ocimem_sequencer.sv
// cpu_debug_ocimem_sequencer: turns debug-slave action strobes into
// single-word OCI memory accesses with address auto-increment.
module cpu_debug_ocimem_sequencer
  import cpu_debug_ocimem_pkg::*;
#(
  parameter int AW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_no_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic          mem_waitrequest,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_rdvalid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  output logic          mem_write,
  output logic [31:0]   mem_wdata,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error,
  output logic          busy,
  output logic          overrun
);

  state_e state;
  cmd_e   cmd;
  logic   any_strobe;
  logic   lost;
  logic   to_clr;
  logic   to_en;
  logic   expired;
  logic   rd_done;
  logic   wr_done;
  logic   abort;
  logic   step;
  logic   unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign cmd = pick_cmd(take_action_ocimem_a,
                        take_no_action_ocimem_a,
                        take_action_ocimem_b);
  assign lost = lost_cmd(take_action_ocimem_a,
                         take_no_action_ocimem_a,
                         take_action_ocimem_b);
  assign any_strobe = take_action_ocimem_a
                    | take_no_action_ocimem_a
                    | take_action_ocimem_b;

  assign to_clr = (state == ST_IDLE);
  assign to_en  = (state != ST_IDLE);

  cpu_debug_ocimem_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk(clk),
    .reset(reset),
    .clr(to_clr),
    .en(to_en),
    .expired(expired)
  );

  // A completion in the expiring cycle wins over the timeout.
  always_comb begin
    rd_done = 1'b0;
    wr_done = 1'b0;
    step    = 1'b0;
    unique case (state)
      ST_RD_REQ: begin
        rd_done = !mem_waitrequest && mem_rdvalid;
        step    = !mem_waitrequest && !mem_rdvalid;
      end
      ST_RD_WAIT: rd_done = mem_rdvalid;
      ST_WR_REQ:  wr_done = !mem_waitrequest;
      default: ;
    endcase
    abort = expired && !rd_done && !wr_done;
    step  = step && !expired;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      mem_addr      <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_wdata     <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
    end else if (state == ST_IDLE) begin
      overrun <= (cmd == CMD_LOAD) ? lost : (overrun | lost);
      unique case (cmd)
        CMD_LOAD: begin
          mem_addr      <= jdo[JDO_ADDR_LSB +: AW];
          monitor_error <= 1'b0;
          if (jdo[JDO_RDFLAG]) begin
            state         <= ST_RD_REQ;
            mem_read      <= 1'b1;
            busy          <= 1'b1;
            monitor_ready <= 1'b0;
          end else begin
            monitor_ready <= 1'b1;
          end
        end
        CMD_READ: begin
          state         <= ST_RD_REQ;
          mem_read      <= 1'b1;
          busy          <= 1'b1;
          monitor_ready <= 1'b0;
          monitor_error <= 1'b0;
        end
        CMD_WRITE: begin
          state         <= ST_WR_REQ;
          mem_write     <= 1'b1;
          mem_wdata     <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
          busy          <= 1'b1;
          monitor_ready <= 1'b0;
          monitor_error <= 1'b0;
        end
        default: ;
      endcase
    end else begin
      if (any_strobe) overrun <= 1'b1;
      unique case (1'b1)
        rd_done: begin
          state         <= ST_IDLE;
          busy          <= 1'b0;
          mem_read      <= 1'b0;
          MonDReg       <= mem_rdata;
          monitor_ready <= 1'b1;
          mem_addr      <= mem_addr + AW'(1);
        end
        wr_done: begin
          state         <= ST_IDLE;
          busy          <= 1'b0;
          mem_write     <= 1'b0;
          monitor_ready <= 1'b1;
          mem_addr      <= mem_addr + AW'(1);
        end
        abort: begin
          state         <= ST_IDLE;
          busy          <= 1'b0;
          mem_read      <= 1'b0;
          mem_write     <= 1'b0;
          monitor_ready <= 1'b1;
          monitor_error <= 1'b1;
        end
        step: begin
          state    <= ST_RD_WAIT;
          mem_read <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_debug_ocimem_sequencer.sv
// tb_cpu_debug_ocimem_sequencer: directed and randomized checks of
// the OCI memory sequencer against a transaction-level model.
module tb_cpu_debug_ocimem_sequencer;

  localparam int AW = 8;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [37:0]   jdo = '0;
  logic          take_action_ocimem_a = 1'b0;
  logic          take_no_action_ocimem_a = 1'b0;
  logic          take_action_ocimem_b = 1'b0;
  logic          mem_waitrequest = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic          mem_rdvalid = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_wdata;
  logic [31:0]   MonDReg;
  logic          monitor_ready;
  logic          monitor_error;
  logic          busy;
  logic          overrun;

  always #5 clk = ~clk;

  cpu_debug_ocimem_sequencer #(
    .AW(AW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .mem_waitrequest(mem_waitrequest),
    .mem_rdata(mem_rdata),
    .mem_rdvalid(mem_rdvalid),
    .mem_addr(mem_addr),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_wdata(mem_wdata),
    .MonDReg(MonDReg),
    .monitor_ready(monitor_ready),
    .monitor_error(monitor_error),
    .busy(busy),
    .overrun(overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // memory responder configuration and state
  int          wait_cfg = 0;
  int          rd_lat = 1;
  bit          rd_en = 1'b1;
  int          wcnt = 0;
  int          rd_left = 0;
  logic [31:0] rd_data_q = '0;
  logic [31:0] arr [256];
  logic [39:0] wr_log [$];

  logic [AW-1:0] cur;
  logic [31:0]   exp_mon;

  always @(negedge clk) begin
    mem_rdvalid = 1'b0;
    mem_waitrequest = 1'b0;
    if (rd_left > 0) begin
      rd_left--;
      if (rd_left == 0 && rd_en) begin
        mem_rdvalid = 1'b1;
        mem_rdata = rd_data_q;
      end
    end
    if (mem_read || mem_write) begin
      if (wcnt < wait_cfg) begin
        mem_waitrequest = 1'b1;
        wcnt++;
      end else begin
        wcnt = 0;
        if (mem_write) begin
          wr_log.push_back({mem_addr, mem_wdata});
        end else begin
          rd_data_q = arr[mem_addr];
          if (rd_lat == 0) begin
            if (rd_en) begin
              mem_rdvalid = 1'b1;
              mem_rdata = rd_data_q;
            end
          end else begin
            rd_left = rd_lat;
          end
        end
      end
    end
  end

  function automatic logic [37:0] rnd38();
    return {6'($urandom()), $urandom()};
  endfunction

  function automatic logic [37:0] mk_a(bit rd, logic [AW-1:0] ad);
    logic [37:0] j = rnd38();
    j[35] = rd;
    j[17 +: AW] = ad;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(logic [31:0] d);
    logic [37:0] j = rnd38();
    j[34:3] = d;
    return j;
  endfunction

  task automatic cyc(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // strobe during one cycle; returns at the following negedge
  task automatic fire(bit ta, bit tn, bit tb, logic [37:0] j);
    take_action_ocimem_a = ta;
    take_no_action_ocimem_a = tn;
    take_action_ocimem_b = tb;
    jdo = j;
    cyc();
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic wait_idle(output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      cyc();
      cycles++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    logic [77:0] v;
    reset = 1'b1;
    cyc(3);
    v = {mem_addr, mem_read, mem_write, mem_wdata, MonDReg,
         monitor_ready, monitor_error, busy, overrun};
    n_cmp++; if (v !== '0) begin n_bad++; $display("FAIL reset_vals: got %h want 0", v); end
    reset = 1'b0;
    cyc(2);
    v = {mem_addr, mem_read, mem_write, mem_wdata, MonDReg,
         monitor_ready, monitor_error, busy, overrun};
    n_cmp++; if (v !== '0) begin n_bad++; $display("FAIL post_reset_idle: got %h want 0", v); end
  endtask

  task automatic test_read_load();
    arr[8'h10] = 32'hDEADBEEF;
    wait_cfg = 0;
    rd_lat = 1;
    fire(1'b1, 1'b0, 1'b0, mk_a(1'b1, 8'h10));
    n_cmp++; if (mem_read !== 1'b1) begin n_bad++; $display("FAIL rl_read_n1: got %b want 1", mem_read); end
    n_cmp++; if (mem_addr !== 8'h10) begin n_bad++; $display("FAIL rl_addr_n1: got %h want 10", mem_addr); end
    n_cmp++; if (monitor_ready !== 1'b0) begin n_bad++; $display("FAIL rl_ready_n1: got %b want 0", monitor_ready); end
    cyc();
    n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL rl_read_n2: got %b want 0", mem_read); end
    cyc();
    n_cmp++; if (MonDReg !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rl_mon_n3: got %h want deadbeef", MonDReg); end
    n_cmp++; if (monitor_ready !== 1'b1) begin n_bad++; $display("FAIL rl_ready_n3: got %b want 1", monitor_ready); end
    n_cmp++; if (mem_addr !== 8'h11) begin n_bad++; $display("FAIL rl_addr_n3: got %h want 11", mem_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rl_busy_n3: got %b want 0", busy); end
    exp_mon = 32'hDEADBEEF;
  endtask

  task automatic test_write_wrap();
    logic [AW-1:0] ea;
    fire(1'b1, 1'b0, 1'b0, mk_a(1'b0, 8'hFE));
    n_cmp++; if (monitor_ready !== 1'b1) begin n_bad++; $display("FAIL ww_load_ready: got %b want 1", monitor_ready); end
    n_cmp++; if (mem_addr !== 8'hFE) begin n_bad++; $display("FAIL ww_load_addr: got %h want fe", mem_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ww_load_busy: got %b want 0", busy); end
    wr_log.delete();
    ea = 8'hFE;
    for (int i = 1; i <= 3; i++) begin
      fire(1'b0, 1'b0, 1'b1, mk_b(32'(i)));
      n_cmp++; if ({mem_write, mem_addr, mem_wdata} !== {1'b1, ea, 32'(i)}) begin n_bad++; $display("FAIL ww_req%0d: got w=%b a=%h d=%h want w=1 a=%h d=%h", i, mem_write, mem_addr, mem_wdata, ea, i); end
      n_cmp++; if (monitor_ready !== 1'b0) begin n_bad++; $display("FAIL ww_busy_ready%0d: got %b want 0", i, monitor_ready); end
      cyc();
      n_cmp++; if ({monitor_ready, busy} !== 2'b10) begin n_bad++; $display("FAIL ww_done%0d: got rdy/busy=%b want 10", i, {monitor_ready, busy}); end
      ea = ea + 8'd1;
    end
    n_cmp++; if (wr_log.size() != 3) begin n_bad++; $display("FAIL ww_count: got %0d want 3", wr_log.size()); end
    else begin
      n_cmp++; if (wr_log[0] !== {8'hFE, 32'd1}) begin n_bad++; $display("FAIL ww_log0: got %h want fe00000001", wr_log[0]); end
      n_cmp++; if (wr_log[1] !== {8'hFF, 32'd2}) begin n_bad++; $display("FAIL ww_log1: got %h want ff00000002", wr_log[1]); end
      n_cmp++; if (wr_log[2] !== {8'h00, 32'd3}) begin n_bad++; $display("FAIL ww_log2: got %h want 0000000003", wr_log[2]); end
    end
    n_cmp++; if (mem_addr !== 8'h01) begin n_bad++; $display("FAIL ww_final_addr: got %h want 01", mem_addr); end
    cur = 8'h01;
  endtask

  task automatic test_wait_read();
    int  rcnt;
    bit  stable;
    wait_cfg = 5;
    rd_lat = 1;
    rcnt = 0;
    stable = 1'b1;
    fire(1'b0, 1'b1, 1'b0, rnd38());
    for (int i = 0; i < 40 && busy; i++) begin
      if (mem_read) rcnt++;
      if (mem_addr !== cur) stable = 1'b0;
      cyc();
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_complete: busy=%b want 0", busy); end
    n_cmp++; if (rcnt != 6) begin n_bad++; $display("FAIL wr_read_cycles: got %0d want 6", rcnt); end
    n_cmp++; if (!stable) begin n_bad++; $display("FAIL wr_addr_stable: got unstable want %h", cur); end
    n_cmp++; if (MonDReg !== arr[cur]) begin n_bad++; $display("FAIL wr_mon: got %h want %h", MonDReg, arr[cur]); end
    n_cmp++; if (mem_addr !== cur + 8'd1) begin n_bad++; $display("FAIL wr_addr_inc: got %h want %h", mem_addr, cur + 8'd1); end
    exp_mon = arr[cur];
    cur = cur + 8'd1;
    wait_cfg = 0;
  endtask

  task automatic test_timeout();
    int bc;
    rd_en = 1'b0;
    bc = 0;
    fire(1'b0, 1'b1, 1'b0, rnd38());
    n_cmp++; if ({monitor_ready, monitor_error} !== 2'b00) begin n_bad++; $display("FAIL to_status_busy: got %b want 00", {monitor_ready, monitor_error}); end
    for (int i = 0; i < 100 && busy; i++) begin
      bc++;
      cyc();
    end
    n_cmp++; if (bc != TO) begin n_bad++; $display("FAIL to_busy_cycles: got %0d want %0d", bc, TO); end
    n_cmp++; if ({monitor_error, monitor_ready, busy} !== 3'b110) begin n_bad++; $display("FAIL to_status: got err/rdy/busy=%b want 110", {monitor_error, monitor_ready, busy}); end
    n_cmp++; if (mem_addr !== cur) begin n_bad++; $display("FAIL to_addr: got %h want %h", mem_addr, cur); end
    n_cmp++; if (MonDReg !== exp_mon) begin n_bad++; $display("FAIL to_mon: got %h want %h", MonDReg, exp_mon); end
    cyc(2);
    rd_en = 1'b1;
  endtask

  task automatic test_priority();
    bit ok;
    int c;
    wr_log.delete();
    fire(1'b1, 1'b0, 1'b1, mk_a(1'b0, 8'h40));
    n_cmp++; if (mem_addr !== 8'h40) begin n_bad++; $display("FAIL pr_addr: got %h want 40", mem_addr); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL pr_overrun: got %b want 1", overrun); end
    n_cmp++; if ({mem_write, busy, monitor_error, monitor_ready} !== 4'b0001) begin n_bad++; $display("FAIL pr_state: got w/busy/err/rdy=%b want 0001", {mem_write, busy, monitor_error, monitor_ready}); end
    cyc(3);
    n_cmp++; if (wr_log.size() != 0) begin n_bad++; $display("FAIL pr_no_write: got %0d writes want 0", wr_log.size()); end
    fire(1'b1, 1'b0, 1'b0, mk_a(1'b0, 8'h41));
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL pr_ovr_clear: got %b want 0", overrun); end
    fire(1'b0, 1'b1, 1'b0, rnd38());
    take_action_ocimem_b = 1'b1;
    jdo = mk_b(32'h5555AAAA);
    cyc();
    take_action_ocimem_b = 1'b0;
    wait_idle(ok, c);
    cyc();
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL pr_idle: busy=%b want 0 after %0d cycles", busy, c); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL pr_busy_drop: got %b want 1", overrun); end
    n_cmp++; if (wr_log.size() != 0) begin n_bad++; $display("FAIL pr_busy_nowrite: got %0d writes want 0", wr_log.size()); end
    n_cmp++; if ({mem_addr, MonDReg} !== {8'h42, arr[8'h41]}) begin n_bad++; $display("FAIL pr_read: got a=%h d=%h want a=42 d=%h", mem_addr, MonDReg, arr[8'h41]); end
  endtask

  task automatic test_random();
    logic [AW-1:0] m_addr;
    logic [31:0]   m_mon;
    logic          m_rdy, m_err, m_ovr;
    logic [39:0]   exp_wr [$];
    bit            ta, tn, tb, inj, ok;
    int            acc, c;
    logic [37:0]   j;
    do_reset();
    wr_log.delete();
    m_addr = '0; m_mon = '0; m_rdy = 0; m_err = 0; m_ovr = 0;
    for (int it = 0; it < 60; it++) begin
      ta = 1'($urandom_range(0, 1));
      tn = 1'($urandom_range(0, 1));
      tb = 1'($urandom_range(0, 1));
      j = rnd38();
      wait_cfg = $urandom_range(0, 3);
      rd_lat = $urandom_range(0, 2);
      acc = 0;
      if (ta) begin
        m_addr = j[17 +: AW];
        m_ovr = tn | tb;
        m_err = 1'b0;
        if (j[35]) acc = 1;
        else m_rdy = 1'b1;
      end else if (tn) begin
        acc = 1;
        m_ovr = m_ovr | tb;
      end else if (tb) begin
        acc = 2;
      end
      if (acc == 1) m_mon = arr[m_addr];
      if (acc == 2) exp_wr.push_back({m_addr, j[34:3]});
      if (acc != 0) begin
        m_addr = m_addr + 8'd1;
        m_rdy = 1'b1;
        m_err = 1'b0;
      end
      inj = (acc != 0) && ($urandom_range(0, 3) == 0);
      if (inj) m_ovr = 1'b1;
      fire(ta, tn, tb, j);
      if (inj) begin
        take_action_ocimem_b = 1'b1;
        cyc();
        take_action_ocimem_b = 1'b0;
      end
      wait_idle(ok, c);
      cyc();
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rnd%0d_idle: busy=%b want 0", it, busy); end
      n_cmp++; if (mem_addr !== m_addr) begin n_bad++; $display("FAIL rnd%0d_addr: got %h want %h", it, mem_addr, m_addr); end
      n_cmp++; if (MonDReg !== m_mon) begin n_bad++; $display("FAIL rnd%0d_mon: got %h want %h", it, MonDReg, m_mon); end
      n_cmp++; if ({monitor_ready, monitor_error, overrun} !== {m_rdy, m_err, m_ovr}) begin n_bad++; $display("FAIL rnd%0d_status: got rdy/err/ovr=%b want %b", it, {monitor_ready, monitor_error, overrun}, {m_rdy, m_err, m_ovr}); end
    end
    n_cmp++; if (wr_log.size() != exp_wr.size()) begin n_bad++; $display("FAIL rnd_wr_count: got %0d want %0d", wr_log.size(), exp_wr.size()); end
    else begin
      foreach (exp_wr[k]) begin
        n_cmp++; if (wr_log[k] !== exp_wr[k]) begin n_bad++; $display("FAIL rnd_wr%0d: got %h want %h", k, wr_log[k], exp_wr[k]); end
      end
    end
    wait_cfg = 0;
    rd_lat = 1;
  endtask

  task automatic test_reset_mid();
    logic [77:0] v;
    cyc(2);
    rd_lat = 3;
    fire(1'b0, 1'b1, 1'b0, rnd38());
    cyc();
    n_cmp++; if ({busy, mem_read} !== 2'b10) begin n_bad++; $display("FAIL rm_in_wait: got busy/read=%b want 10", {busy, mem_read}); end
    reset = 1'b1;
    cyc();
    v = {mem_addr, mem_read, mem_write, mem_wdata, MonDReg,
         monitor_ready, monitor_error, busy, overrun};
    n_cmp++; if (v !== '0) begin n_bad++; $display("FAIL rm_reset_vals: got %h want 0", v); end
    reset = 1'b0;
    cyc(4);
    n_cmp++; if ({MonDReg, monitor_ready, busy, mem_addr} !== '0) begin n_bad++; $display("FAIL rm_late_rdvalid: got mon=%h rdy=%b busy=%b a=%h want all 0", MonDReg, monitor_ready, busy, mem_addr); end
    rd_lat = 1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) arr[i] = $urandom();
    test_reset();
    test_read_load();
    test_write_wrap();
    test_wait_read();
    test_timeout();
    test_priority();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
